// File: rtl/dmem_bus_bridge_pkg.sv
// dmem_bus_bridge_pkg
//   Shared encodings for the data-memory bus bridge: bridge FSM states,
//   byte-enable patterns and the alignment rule applied to core accesses.
package dmem_bus_bridge_pkg;

    typedef enum logic [1:0] {
        BRG_IDLE = 2'd0,
        BRG_REQ  = 2'd1,
        BRG_DONE = 2'd2
    } brg_state_e;

    localparam logic [3:0] BE_WORD    = 4'b1111;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;

    // Word accesses need addr[1:0]==0, halfword accesses need addr[0]==0.
    // Single-byte and other enable patterns are never misaligned.
    function automatic logic is_misaligned(input logic [1:0] addr_lo, input logic [3:0] be);
        return ((be == BE_WORD) && (addr_lo != 2'b00)) ||
               (((be == BE_HALF_LO) || (be == BE_HALF_HI)) && addr_lo[0]);
    endfunction

endpackage

// File: rtl/bus_timeout_cnt.sv
// bus_timeout_cnt
//   Counts cycles while a bus request is outstanding and flags the cycle on
//   which the request has been held for TIMEOUT cycles.
// Ports:
//   clk, rst  clock, synchronous active-high reset
//   clr       force the count to zero (takes priority over en)
//   en        count this cycle
//   expire    high during the TIMEOUT-th enabled cycle since the last clear
module bus_timeout_cnt #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned TO_W    = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    logic [TO_W-1:0] cnt_q;
    logic [TO_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + TO_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Count starts at 0 in the first enabled cycle, so TIMEOUT-1 marks the
    // TIMEOUT-th cycle of the request.
    assign expire = en && (cnt_q == TO_W'(TIMEOUT - 1));

endmodule

// File: rtl/dmem_bus_bridge.sv
// dmem_bus_bridge
//   Turns the single-cycle core's data-memory load/store into a req/ack bus
//   transaction, stalling the core until the access completes. Misaligned,
//   slave-errored and timed-out accesses return ERR_RDATA and set a sticky
//   error flag.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   dmem_addr/din/be/wren/rden    core request (held by the core while stalled)
//   dmem_dout                     load data, valid in the DONE cycle, held after
//   stall                         core must hold PC and not commit
//   bus_req/we/addr/wdata/be      registered bus request, stable while pending
//   bus_ack/rdata/err             bus response
//   err_flag                      sticky error, cleared only by rst
module dmem_bus_bridge #(
    parameter int unsigned TIMEOUT   = 255,
    parameter int unsigned TO_W      = 8,
    parameter logic [31:0] ERR_RDATA = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_din,
    input  logic [3:0]  dmem_be,
    input  logic        dmem_wren,
    input  logic        dmem_rden,
    output logic [31:0] dmem_dout,
    output logic        stall,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    input  logic        bus_err,
    output logic        err_flag
);

    import dmem_bus_bridge_pkg::*;

    brg_state_e  state_q,     state_d;
    logic        bus_req_q,   bus_req_d;
    logic        bus_we_q,    bus_we_d;
    logic [31:0] bus_addr_q,  bus_addr_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic [3:0]  bus_be_q,    bus_be_d;
    logic [31:0] dmem_dout_q, dmem_dout_d;
    logic        err_flag_q,  err_flag_d;
    // Store that was also flagged as a load: its load data is ERR_RDATA.
    logic        rd_too_q,    rd_too_d;

    logic        core_req;
    logic        to_expire;

    assign core_req = dmem_wren | dmem_rden;

    bus_timeout_cnt #(
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clr    (state_q != BRG_REQ),
        .en     (state_q == BRG_REQ),
        .expire (to_expire)
    );

    always_comb begin
        state_d     = state_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        bus_be_d    = bus_be_q;
        dmem_dout_d = dmem_dout_q;
        err_flag_d  = err_flag_q;
        rd_too_d    = rd_too_q;
        stall       = 1'b0;

        case (state_q)
            BRG_IDLE: begin
                stall = core_req;
                if (core_req) begin
                    bus_addr_d  = {dmem_addr[31:2], 2'b00};
                    bus_wdata_d = dmem_din;
                    bus_be_d    = dmem_be;
                    bus_we_d    = dmem_wren;
                    rd_too_d    = dmem_wren & dmem_rden;
                    if (is_misaligned(dmem_addr[1:0], dmem_be)) begin
                        dmem_dout_d = ERR_RDATA;
                        err_flag_d  = 1'b1;
                        state_d     = BRG_DONE;
                    end else begin
                        bus_req_d = 1'b1;
                        state_d   = BRG_REQ;
                    end
                end
            end
            BRG_REQ: begin
                stall = 1'b1;
                if (bus_err) begin
                    dmem_dout_d = ERR_RDATA;
                    err_flag_d  = 1'b1;
                    bus_req_d   = 1'b0;
                    state_d     = BRG_DONE;
                end else if (bus_ack) begin
                    if (!bus_we_q) begin
                        dmem_dout_d = bus_rdata;
                    end else if (rd_too_q) begin
                        dmem_dout_d = ERR_RDATA;
                    end
                    bus_req_d = 1'b0;
                    state_d   = BRG_DONE;
                end else if (to_expire) begin
                    dmem_dout_d = ERR_RDATA;
                    err_flag_d  = 1'b1;
                    bus_req_d   = 1'b0;
                    state_d     = BRG_DONE;
                end
            end
            BRG_DONE: begin
                // Request inputs are deliberately ignored here: the core is
                // still presenting the access it is about to commit.
                state_d = BRG_IDLE;
            end
            default: begin
                state_d = BRG_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= BRG_IDLE;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            bus_be_q    <= '0;
            dmem_dout_q <= '0;
            err_flag_q  <= 1'b0;
            rd_too_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_be_q    <= bus_be_d;
            dmem_dout_q <= dmem_dout_d;
            err_flag_q  <= err_flag_d;
            rd_too_q    <= rd_too_d;
        end
    end

    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign bus_be    = bus_be_q;
    assign dmem_dout = dmem_dout_q;
    assign err_flag  = err_flag_q;

endmodule

// File: tb/tb_dmem_bus_bridge.sv
// Bench for dmem_bus_bridge. Each access is described at transaction level
// (request, wait cycles, response kind); the expected per-cycle outputs are
// derived from that description and checked every cycle at the falling edge.
module tb_dmem_bus_bridge;

    localparam int unsigned TIMEOUT   = 255;
    localparam logic [31:0] ERR_RDATA = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_din;
    logic [3:0]  dmem_be;
    logic        dmem_wren;
    logic        dmem_rden;
    logic [31:0] dmem_dout;
    logic        stall;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic        bus_err;
    logic        err_flag;

    dmem_bus_bridge #(
        .TIMEOUT   (TIMEOUT),
        .TO_W      (8),
        .ERR_RDATA (ERR_RDATA)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .dmem_addr (dmem_addr),
        .dmem_din  (dmem_din),
        .dmem_be   (dmem_be),
        .dmem_wren (dmem_wren),
        .dmem_rden (dmem_rden),
        .dmem_dout (dmem_dout),
        .stall     (stall),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_be    (bus_be),
        .bus_ack   (bus_ack),
        .bus_rdata (bus_rdata),
        .bus_err   (bus_err),
        .err_flag  (err_flag)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic chk_en = 1'b0;

    // Expected outputs for the current cycle.
    logic        exp_stall, exp_req, exp_we, exp_err;
    logic [31:0] exp_addr, exp_wdata, exp_dout;
    logic [3:0]  exp_be;

    int stall_total = 0;
    int req_total   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("stall",     {31'd0, stall},    {31'd0, exp_stall});
            check("bus_req",   {31'd0, bus_req},  {31'd0, exp_req});
            check("bus_we",    {31'd0, bus_we},   {31'd0, exp_we});
            check("bus_addr",  bus_addr,          exp_addr);
            check("bus_wdata", bus_wdata,         exp_wdata);
            check("bus_be",    {28'd0, bus_be},   {28'd0, exp_be});
            check("dmem_dout", dmem_dout,         exp_dout);
            check("err_flag",  {31'd0, err_flag}, {31'd0, exp_err});
            if (stall)   stall_total++;
            if (bus_req) req_total++;
        end
    end

    function automatic logic misaligned(input logic [1:0] a, input logic [3:0] be);
        return (be == 4'b1111 && a != 2'b00) || ((be == 4'b0011 || be == 4'b1100) && a[0]);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_reset_model();
        exp_stall = 1'b0; exp_req = 1'b0; exp_we = 1'b0; exp_err = 1'b0;
        exp_addr = '0; exp_wdata = '0; exp_dout = '0; exp_be = '0;
    endtask

    // Responses while no request is pending must be ignored.
    task automatic noise();
        bus_ack   = 1'($urandom_range(0, 1));
        bus_err   = 1'($urandom_range(0, 1));
        bus_rdata = $urandom;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            dmem_wren = 1'b0;
            dmem_rden = 1'b0;
            dmem_addr = $urandom;
            dmem_din  = $urandom;
            dmem_be   = 4'($urandom_range(0, 15));
            noise();
            exp_stall = 1'b0;
            exp_req   = 1'b0;
            step();
        end
    endtask

    // One core access. k = wait cycles before the response (k < 0: none).
    // kind: 0 ack, 1 err, 2 ack and err together.
    task automatic run_txn(input logic wr, input logic rd, input logic [31:0] addr,
                           input logic [31:0] din, input logic [3:0] be,
                           input int k, input int kind, input logic [31:0] rdata);
        logic bad;
        logic timed_out;
        int   r;
        bad = misaligned(addr[1:0], be);
        dmem_addr = addr; dmem_din = din; dmem_be = be;
        dmem_wren = wr;   dmem_rden = rd;
        noise();
        exp_stall = 1'b1;
        exp_req   = 1'b0;
        step();
        exp_addr  = {addr[31:2], 2'b00};
        exp_wdata = din;
        exp_be    = be;
        exp_we    = wr;
        if (bad) begin
            noise();
            exp_stall = 1'b0;
            exp_req   = 1'b0;
            exp_dout  = ERR_RDATA;
            exp_err   = 1'b1;
            step();
            return;
        end
        timed_out = (k < 0) || (k >= int'(TIMEOUT));
        r = timed_out ? int'(TIMEOUT) - 1 : k;
        for (int i = 0; i <= r; i++) begin
            bus_ack   = 1'b0;
            bus_err   = 1'b0;
            bus_rdata = $urandom;
            if (!timed_out && i == k) begin
                bus_rdata = rdata;
                bus_ack   = (kind != 1);
                bus_err   = (kind != 0);
            end
            exp_stall = 1'b1;
            exp_req   = 1'b1;
            step();
        end
        exp_stall = 1'b0;
        exp_req   = 1'b0;
        if (timed_out || kind != 0) begin
            exp_dout = ERR_RDATA;
            exp_err  = 1'b1;
        end else if (!wr) begin
            exp_dout = rdata;
        end else if (rd) begin
            exp_dout = ERR_RDATA;
        end
        noise();
        step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, q0;
        logic [3:0] be_tab [7];
        be_tab = '{4'b1111, 4'b0011, 4'b1100, 4'b0001, 4'b0010, 4'b0100, 4'b1000};

        rst = 1'b1;
        dmem_addr = '0; dmem_din = '0; dmem_be = '0; dmem_wren = 1'b0; dmem_rden = 1'b0;
        bus_ack = 1'b0; bus_err = 1'b0; bus_rdata = '0;
        set_reset_model();
        step();
        chk_en = 1'b1;
        step();
        rst = 1'b0;
        idle(2);

        // Zero-wait store
        s0 = stall_total; q0 = req_total;
        run_txn(1'b1, 1'b0, 32'h100, 32'h1234_5678, 4'b1111, 0, 0, 32'h0);
        check("store_stall_cycles", 32'(stall_total - s0), 32'd2);
        check("store_req_cycles",   32'(req_total - q0),   32'd1);
        check("store_bus_addr",     bus_addr,  32'h0000_0100);
        check("store_bus_wdata",    bus_wdata, 32'h1234_5678);
        check("store_bus_we",       {31'd0, bus_we},   32'd1);
        check("store_err_flag",     {31'd0, err_flag}, 32'd0);
        idle(1);

        // Load with 3 wait cycles
        s0 = stall_total; q0 = req_total;
        run_txn(1'b0, 1'b1, 32'h204, 32'h0, 4'b1111, 3, 0, 32'hCAFE_F00D);
        check("load_req_cycles",   32'(req_total - q0),   32'd4);
        check("load_stall_cycles", 32'(stall_total - s0), 32'd5);
        check("load_dout",         dmem_dout, 32'hCAFE_F00D);
        idle(1);

        // Misaligned word load
        s0 = stall_total; q0 = req_total;
        run_txn(1'b0, 1'b1, 32'h102, 32'h0, 4'b1111, 0, 0, 32'h1111_1111);
        check("misal_req_cycles",   32'(req_total - q0),   32'd0);
        check("misal_stall_cycles", 32'(stall_total - s0), 32'd1);
        check("misal_dout",         dmem_dout, 32'h0);
        check("misal_err_flag",     {31'd0, err_flag}, 32'd1);
        idle(2);

        // Timeout, then a normal access
        q0 = req_total;
        run_txn(1'b0, 1'b1, 32'h300, 32'h0, 4'b1111, -1, 0, 32'h0);
        check("timeout_req_cycles", 32'(req_total - q0), 32'd255);
        check("timeout_dout",       dmem_dout, 32'h0);
        idle(1);
        run_txn(1'b0, 1'b1, 32'h304, 32'h0, 4'b1111, 1, 0, 32'h5A5A_1234);
        check("after_timeout_dout", dmem_dout, 32'h5A5A_1234);
        check("err_flag_sticky",    {31'd0, err_flag}, 32'd1);
        idle(1);

        // Error and ack together on a load
        run_txn(1'b0, 1'b1, 32'h308, 32'h0, 4'b1111, 1, 2, 32'h7777_7777);
        check("err_ack_dout", dmem_dout, 32'h0);
        idle(1);

        // Reset on the second REQ cycle of a store
        dmem_addr = 32'h400; dmem_din = 32'hDEAD_BEEF; dmem_be = 4'b1111;
        dmem_wren = 1'b1; dmem_rden = 1'b0;
        bus_ack = 1'b0; bus_err = 1'b0;
        exp_stall = 1'b1; exp_req = 1'b0;
        step();
        exp_addr = 32'h400; exp_wdata = 32'hDEAD_BEEF; exp_be = 4'b1111; exp_we = 1'b1;
        exp_req = 1'b1;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        dmem_wren = 1'b0;
        set_reset_model();
        check("rst_bus_req",  {31'd0, bus_req},  32'd0);
        check("rst_err_flag", {31'd0, err_flag}, 32'd0);
        check("rst_bus_addr", bus_addr, 32'h0);
        idle(2);
        run_txn(1'b1, 1'b0, 32'h404, 32'hA5A5_0F0F, 4'b1111, 2, 0, 32'h0);
        check("post_rst_wdata",    bus_wdata, 32'hA5A5_0F0F);
        check("post_rst_err_flag", {31'd0, err_flag}, 32'd0);
        idle(1);

        // Randomised accesses
        for (int n = 0; n < 120; n++) begin
            logic wr, rd;
            int   kr, kind;
            wr = 1'($urandom_range(0, 1));
            rd = 1'($urandom_range(0, 1));
            if (!wr && !rd) rd = 1'b1;
            kr = int'($urandom_range(0, 9));
            kind = (kr < 8) ? 0 : (kr == 8 ? 1 : 2);
            run_txn(wr, rd, $urandom & 32'h0000_FFFF, $urandom,
                    be_tab[$urandom_range(0, 6)], int'($urandom_range(0, 5)), kind, $urandom);
            idle(int'($urandom_range(0, 2)));
        end

        idle(2);
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
